corr_pkt_arbiter: RTL and testbench
===================================

CORR_PKT_ARBITER -- requirements
Module: corr_pkt_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of correlator packet sources (2..16).
REQ-002 SHALL have parameter PKT_BYTES, default 5, bytes per source packet (winNum, countX, countY, countIsect, countSymdiff).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_cg  input  1  clock-gate enable; low freezes all state.
REQ-006 SHALL have port i_flush  input  1  abort any packet in flight.
REQ-007 SHALL have port i_pkt_valid  input  N_CH  per-source packet available.
REQ-008 SHALL have port i_pkt_data  input  N_CH*PKT_BYTES*8  per-source packet; source s occupies slice [s*PKT_BYTES*8 +: PKT_BYTES*8]; byte k at bits [8k +: 8].
REQ-009 SHALL have port o_pkt_ready  output  N_CH  one-hot capture pulse to the granted source.
REQ-010 SHALL have port o_bp_data  output  8  output byte stream.
REQ-011 SHALL have port o_bp_valid  output  1  o_bp_data valid.
REQ-012 SHALL have port i_bp_ready  input  1  downstream accepts byte.
REQ-013 SHALL have port o_grant  output  4  index of the source last granted.
REQ-014 SHALL have port o_busy  output  1  high while state is SEND.

Function
REQ-015 SHALL implement two states: IDLE, SEND.
REQ-016 In IDLE with i_cg=1, i_flush=0 and any i_pkt_valid set, SHALL grant one source, chosen round-robin starting at (o_grant+1) mod N_CH.
REQ-017 SHALL assert o_pkt_ready for the granted source combinationally in that cycle only; a transfer occurs when valid and ready are both high.
REQ-018 o_pkt_ready SHALL be all-zero outside IDLE, when i_cg=0, when i_flush=1, and during reset.
REQ-019 On the grant, the module SHALL latch the source packet into a capture register, update o_grant, clear the byte index, and enter SEND on the next cycle.
REQ-020 In SEND, o_bp_valid SHALL be 1, and the frame SHALL be PKT_BYTES+1 bytes: byte 0 = {4'hC, grant[3:0]} header; bytes 1..PKT_BYTES = captured bytes 0..PKT_BYTES-1, in order.
REQ-021 The byte index SHALL advance only when o_bp_valid and i_bp_ready are both high with i_cg=1; o_bp_data SHALL hold stable while i_bp_ready is low.
REQ-022 Acceptance of the final byte SHALL return the state to IDLE; the next grant occurs no earlier than the following cycle, so there is one bubble cycle between frames.
REQ-023 Latency: source valid at cycle t in IDLE -> header on o_bp_valid at t+1.
REQ-024 i_flush=1 SHALL force IDLE and byte index 0 on the next edge, discarding the captured packet; o_grant SHALL be unchanged.
REQ-025 i_flush and a final-byte acceptance in the same cycle SHALL both resolve to IDLE; the byte counts as accepted.
REQ-026 The module SHALL never drop or reorder bytes within a frame, and no source SHALL be granted twice while another valid source waits.
REQ-027 Round-robin pointer arithmetic SHALL wrap modulo N_CH.

Reset
REQ-028 On i_rst, the state SHALL be IDLE, the byte index 0, o_grant = N_CH-1 (so source 0 has first priority), the capture register 0, o_bp_valid 0, o_busy 0, and o_pkt_ready 0.
REQ-029 i_rst SHALL take priority over i_cg and i_flush; reset mid-frame abandons the frame with no further bytes.

Structure
REQ-030 The frame header constant 4'hC, state encodings, and header width SHALL live in a shared correlator packet header.
REQ-031 The round-robin selection SHALL be a combinational sub-module rr_pick(N_CH), with inputs request vector and last index, and outputs one-hot grant plus index.
REQ-032 All flops SHALL use the codebase dff macros with synchronous reset; the total SHALL be 120-400 lines.

Verification
REQ-033 Reset, then source 0 valid with data 0x0403020100 and i_bp_ready=1 -> bytes C0,00,01,02,03,04 on consecutive cycles; o_pkt_ready[0] pulses once.
REQ-034 All 4 sources continuously valid -> header sequence C0,C1,C2,C3,C0 with one bubble between frames.
REQ-035 i_bp_ready toggling 1,0,0,1 mid-frame -> o_bp_data holds during stall; the frame is complete and in order.
REQ-036 i_flush at byte 3 of the source 2 frame -> IDLE next cycle with no further bytes; o_grant=2; next grant goes to source 3 if it is valid.
REQ-037 i_cg=0 for 5 cycles mid-frame -> no byte advance and o_pkt_ready=0; the frame resumes intact when i_cg returns to 1.
REQ-038 i_rst asserted at byte 2 -> o_bp_valid=0 next cycle; o_grant=3; the first post-reset grant goes to source 0.

Source files
------------

// File: rtl/corr_pkt_arbiter_pkg.sv
// Shared correlator packet definitions: frame header tag, header width and
// arbiter state encodings.
package corr_pkt_arbiter_pkg;

  localparam int               HDR_W   = 4;
  localparam logic [HDR_W-1:0] HDR_TAG = 4'hC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arbState_t;

  // Frame header byte: tag nibble followed by the granted source index.
  function automatic logic [7:0] hdrByte(input logic [3:0] src);
    return {HDR_TAG, src};
  endfunction

endpackage

// File: rtl/corr_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: searches the request vector starting one
// past the last granted index, wrapping modulo N_CH.
module rr_pick #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic [3:0]      lastIdx,
  output logic [N_CH-1:0] grantOh,
  output logic [3:0]      grantIdx,
  output logic            anyReq
);

  // First requester found walking forward from lastIdx+1 wins.
  always_comb begin
    int c;
    grantOh  = '0;
    grantIdx = '0;
    anyReq   = 1'b0;
    c        = 0;
    for (int i = 0; i < N_CH; i++) begin
      c = (int'(lastIdx) + 1 + i) % N_CH;
      if (!anyReq && req[c]) begin
        anyReq      = 1'b1;
        grantOh[c]  = 1'b1;
        grantIdx    = 4'(c);
      end
    end
  end

endmodule

// File: rtl/corr_pkt_arbiter.sv
// Correlator packet arbiter: grants one source at a time round-robin,
// captures its packet and streams it out as a header byte plus payload.
//
// state   | meaning
// IDLE    | waiting for a valid source; grants and captures in one cycle
// SEND    | streaming header then captured bytes under downstream ready
module corr_pkt_arbiter
  import corr_pkt_arbiter_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int PKT_BYTES = 5
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cg,
  input  logic                        i_flush,
  input  logic [N_CH-1:0]             i_pkt_valid,
  input  logic [N_CH*PKT_BYTES*8-1:0] i_pkt_data,
  output logic [N_CH-1:0]             o_pkt_ready,
  output logic [7:0]                  o_bp_data,
  output logic                        o_bp_valid,
  input  logic                        i_bp_ready,
  output logic [3:0]                  o_grant,
  output logic                        o_busy
);

  localparam int               PKT_W     = PKT_BYTES * 8;
  localparam int               IDX_W     = $clog2(PKT_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKT_BYTES);
  localparam logic [3:0]       GRANT_RST = 4'(N_CH - 1);

  arbState_t        stateQ, stateD;
  logic [IDX_W-1:0] byteIdxQ, byteIdxD;
  logic [PKT_W-1:0] capQ, capD;
  logic [3:0]       grantQ, grantD;
  logic [N_CH-1:0]  pickOh;
  logic [3:0]       pickIdx;
  logic             pickAny;
  logic [PKT_W-1:0] pktSel;
  logic             grantFire;

  rr_pick #(.N_CH(N_CH)) uPick (
    .req      (i_pkt_valid),
    .lastIdx  (grantQ),
    .grantOh  (pickOh),
    .grantIdx (pickIdx),
    .anyReq   (pickAny)
  );

  // Mux out the packet of the source the picker selected.
  always_comb begin
    pktSel = '0;
    for (int s = 0; s < N_CH; s++) begin
      if (pickIdx == 4'(s)) pktSel = i_pkt_data[s*PKT_W +: PKT_W];
    end
  end

  // Reset is folded in so the capture pulse is never seen during reset.
  assign grantFire   = (stateQ == ST_IDLE) && i_cg && !i_flush && !i_rst && pickAny;
  assign o_pkt_ready = grantFire ? pickOh : '0;

  // Next-state logic; a flush on the final byte also lands in IDLE, so the
  // byte still counts as delivered.
  always_comb begin
    stateD   = stateQ;
    byteIdxD = byteIdxQ;
    capD     = capQ;
    grantD   = grantQ;
    if (i_cg) begin
      if (i_flush) begin
        stateD   = ST_IDLE;
        byteIdxD = '0;
        capD     = '0;
      end else begin
        case (stateQ)
          ST_IDLE: begin
            if (pickAny) begin
              stateD   = ST_SEND;
              byteIdxD = '0;
              capD     = pktSel;
              grantD   = pickIdx;
            end
          end
          ST_SEND: begin
            if (i_bp_ready) begin
              if (byteIdxQ == LAST_IDX) begin
                stateD   = ST_IDLE;
                byteIdxD = '0;
              end else begin
                byteIdxD = byteIdxQ + IDX_W'(1);
              end
            end
          end
          default: stateD = ST_IDLE;
        endcase
      end
    end
  end

  // State registers with synchronous reset; grant resets so source 0 goes first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stateQ   <= ST_IDLE;
      byteIdxQ <= '0;
      capQ     <= '0;
      grantQ   <= GRANT_RST;
    end else begin
      stateQ   <= stateD;
      byteIdxQ <= byteIdxD;
      capQ     <= capD;
      grantQ   <= grantD;
    end
  end

  // Output byte: header at index 0, captured bytes at 1..PKT_BYTES.
  always_comb begin
    o_bp_data = hdrByte(grantQ);
    for (int k = 0; k < PKT_BYTES; k++) begin
      if (byteIdxQ == IDX_W'(k + 1)) o_bp_data = capQ[k*8 +: 8];
    end
  end

  assign o_bp_valid = (stateQ == ST_SEND);
  assign o_busy     = (stateQ == ST_SEND);
  assign o_grant    = grantQ;

endmodule

// File: tb/tb_corr_pkt_arbiter.sv
// Bench for corr_pkt_arbiter: combinational grant table plus scripted
// multi-cycle sequences; output bytes are checked against a queue of
// expected bytes filled when each packet is offered.
module tb_corr_pkt_arbiter;

  localparam int N_CH      = 4;
  localparam int PKT_BYTES = 5;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        cg;
  logic                        flush;
  logic [N_CH-1:0]             pktValid;
  logic [N_CH*PKT_BYTES*8-1:0] pktData;
  logic [N_CH-1:0]             pktReady;
  logic [7:0]                  bpData;
  logic                        bpValid;
  logic                        bpReady;
  logic [3:0]                  grant;
  logic                        busy;

  int nChecks = 0;
  int nErrors = 0;
  int cyc     = 0;
  logic [7:0] expQ[$];
  int         acc[$];

  corr_pkt_arbiter #(.N_CH(N_CH), .PKT_BYTES(PKT_BYTES)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cg        (cg),
    .i_flush     (flush),
    .i_pkt_valid (pktValid),
    .i_pkt_data  (pktData),
    .o_pkt_ready (pktReady),
    .o_bp_data   (bpData),
    .o_bp_valid  (bpValid),
    .i_bp_ready  (bpReady),
    .o_grant     (grant),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every accepted byte must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && cg && bpValid && bpReady) begin
      acc.push_back(cyc);
      if (expQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("FAIL unexpected_byte: got=%0h expected=none (cycle %0d)", bpData, cyc);
      end else begin
        chk("stream_byte", {24'd0, bpData}, {24'd0, expQ.pop_front()});
      end
      chk("busy_eq_valid", {31'd0, busy}, 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pushFrame(input int s);
    logic [3:0] s4;
    s4 = 4'(s);
    expQ.push_back({4'hC, s4});
    for (int k = 0; k < PKT_BYTES; k++) expQ.push_back(8'(s * 16 + k));
  endtask

  task automatic waitEmpty(input string name, input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++;
      $display("FAIL %s_timeout: got=%0d bytes left expected=0", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic doReset();
    rst      = 1'b1;
    cg       = 1'b1;
    flush    = 1'b0;
    pktValid = '0;
    bpReady  = 1'b1;
    expQ.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       cg;
    logic       flush;
    logic       rst;
    logic [3:0] expReady;
  } vec_t;

  vec_t vecs[8];

  initial begin
    for (int s = 0; s < N_CH; s++)
      for (int k = 0; k < PKT_BYTES; k++)
        pktData[(s*PKT_BYTES + k)*8 +: 8] = 8'(s * 16 + k);

    vecs[0] = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001};
    vecs[1] = '{4'b0110, 1'b1, 1'b0, 1'b0, 4'b0010};
    vecs[2] = '{4'b1100, 1'b1, 1'b0, 1'b0, 4'b0100};
    vecs[3] = '{4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000};
    vecs[4] = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[5] = '{4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[6] = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[7] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};

    // Reset state.
    rst      = 1'b1;
    cg       = 1'b1;
    flush    = 1'b0;
    pktValid = '0;
    bpReady  = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, bpValid}, 32'd0);
    chk("rst_busy",  {31'd0, busy},    32'd0);
    chk("rst_grant", {28'd0, grant},   32'd3);
    chk("rst_ready", {28'd0, pktReady}, 32'd0);
    rst = 1'b0;
    tick();

    // Combinational grant table in IDLE with o_grant = 3 (no edge taken).
    for (int i = 0; i < 8; i++) begin
      tick();
      pktValid = vecs[i].valid;
      cg       = vecs[i].cg;
      flush    = vecs[i].flush;
      rst      = vecs[i].rst;
      #1;
      chk($sformatf("tbl_ready[%0d]", i), {28'd0, pktReady}, {28'd0, vecs[i].expReady});
      chk($sformatf("tbl_busy[%0d]", i),  {31'd0, busy}, 32'd0);
      pktValid = '0;
      cg       = 1'b1;
      flush    = 1'b0;
      rst      = 1'b0;
    end

    // Single packet from source 0, header the cycle after the grant.
    doReset();
    pushFrame(0);
    acc.delete();
    pktValid = 4'b0001;
    #1 chk("t1_ready_pulse", {28'd0, pktReady}, 32'h1);
    tick();
    pktValid = '0;
    #1;
    chk("t1_hdr_valid", {31'd0, bpValid}, 32'd1);
    chk("t1_hdr_data",  {24'd0, bpData},  32'hC0);
    chk("t1_ready_off", {28'd0, pktReady}, 32'd0);
    waitEmpty("t1", 20);
    chk("t1_nbytes", acc.size(), 32'd6);
    if (acc.size() == 6) chk("t1_consecutive", acc[5] - acc[0], 32'd5);
    tick();
    chk("t1_idle_after", {31'd0, bpValid}, 32'd0);

    // All sources valid: round-robin 0,1,2,3,0 with a bubble between frames.
    doReset();
    pushFrame(0); pushFrame(1); pushFrame(2); pushFrame(3); pushFrame(0);
    acc.delete();
    pktValid = 4'b1111;
    waitEmpty("t2", 80);
    pktValid = '0;
    chk("t2_nbytes", acc.size(), 32'd30);
    if (acc.size() == 30) chk("t2_span", acc[29] - acc[0], 32'd33);
    tick(); tick();
    chk("t2_idle_after", {31'd0, bpValid}, 32'd0);

    // Downstream stall: ready 1,0,0,1 while byte index 2 is on the bus.
    doReset();
    pushFrame(1);
    pktValid = 4'b0010;
    tick();
    pktValid = '0;
    tick();
    tick();
    bpReady = 1'b0;
    #1 chk("t3_stall0", {24'd0, bpData}, 32'h11);
    tick();
    #1 chk("t3_stall1", {24'd0, bpData}, 32'h11);
    tick();
    bpReady = 1'b1;
    #1 chk("t3_resume", {24'd0, bpData}, 32'h11);
    waitEmpty("t3", 20);

    // Flush at byte 3 of the source 2 frame; source 3 is served next.
    doReset();
    expQ.push_back(8'hC2);
    expQ.push_back(8'h20);
    expQ.push_back(8'h21);
    pktValid = 4'b1100;
    #1 chk("t4_grant2", {28'd0, pktReady}, 32'h4);
    tick();
    pktValid = 4'b1000;
    tick();
    tick();
    tick();
    flush   = 1'b1;
    bpReady = 1'b0;
    #1;
    chk("t4_flush_byte", {24'd0, bpData}, 32'h22);
    chk("t4_flush_ready", {28'd0, pktReady}, 32'd0);
    chk("t4_prefix_done", expQ.size(), 32'd0);
    pushFrame(3);
    tick();
    flush   = 1'b0;
    bpReady = 1'b1;
    #1;
    chk("t4_idle_valid", {31'd0, bpValid}, 32'd0);
    chk("t4_grant_kept", {28'd0, grant}, 32'd2);
    chk("t4_next_src3", {28'd0, pktReady}, 32'h8);
    tick();
    pktValid = '0;
    waitEmpty("t4", 20);
    chk("t4_grant3", {28'd0, grant}, 32'd3);

    // Clock gate low for five cycles mid-frame.
    doReset();
    pushFrame(0);
    pktValid = 4'b0001;
    tick();
    pktValid = '0;
    tick();
    tick();
    cg       = 1'b0;
    pktValid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t5_hold[%0d]", i), {24'd0, bpData}, 32'h01);
      chk($sformatf("t5_ready[%0d]", i), {28'd0, pktReady}, 32'd0);
      tick();
    end
    cg       = 1'b1;
    pktValid = '0;
    waitEmpty("t5", 20);

    // Reset mid-frame at byte 2.
    doReset();
    expQ.push_back(8'hC2);
    expQ.push_back(8'h20);
    pktValid = 4'b0100;
    tick();
    pktValid = '0;
    tick();
    tick();
    rst      = 1'b1;
    pktValid = 4'b1111;
    #1 chk("t6_ready_in_rst", {28'd0, pktReady}, 32'd0);
    tick();
    rst      = 1'b0;
    pktValid = 4'b0101;
    #1;
    chk("t6_valid_off", {31'd0, bpValid}, 32'd0);
    chk("t6_busy_off",  {31'd0, busy},    32'd0);
    chk("t6_grant3",    {28'd0, grant},   32'd3);
    chk("t6_first_src0", {28'd0, pktReady}, 32'h1);
    chk("t6_no_more_bytes", expQ.size(), 32'd0);
    expQ.delete();
    pushFrame(0);
    tick();
    pktValid = '0;
    waitEmpty("t6", 20);
    chk("t6_grant0", {28'd0, grant}, 32'd0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
